// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control path.
//   - register-file geometry (address/data widths)
//   - instruction field positions and opcode constants
//   - sequencer state encoding
//   - opcode classification helpers used by the sequencer
package cpu_pkg;

    localparam int unsigned RF_ADDR_W = 4;
    localparam int unsigned RF_DATA_W = 8;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned IMM_W     = 8;

    // Instruction fields: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2, [7:0] imm8
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h6;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_BEQZ = 4'h9;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StRead   = 3'd3,
        StExec   = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    function automatic logic op_is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    // Ops that need operands from the register file (BEQZ reads rd via port 1)
    function automatic logic op_reads_rf(input logic [OPC_W-1:0] op);
        return op_is_alu(op) || (op == OP_MOV) || (op == OP_BEQZ);
    endfunction

    function automatic logic op_writes_rf(input logic [OPC_W-1:0] op);
        return op_is_alu(op) || (op == OP_MOV) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 8-bit ALU.
//   i_op     opcode (ADD/SUB/AND/OR/XOR; anything else yields 0)
//   i_a/i_b  operands
//   o_result low 8 bits of the result
//   o_carry  ADD carry-out / SUB borrow (rs1 < rs2)
//   o_zero   o_result == 0
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0]     i_op,
    input  logic [RF_DATA_W-1:0] i_a,
    input  logic [RF_DATA_W-1:0] i_b,
    output logic [RF_DATA_W-1:0] o_result,
    output logic                 o_carry,
    output logic                 o_zero
);

    // 9-bit result: bit 8 is carry for ADD and borrow for SUB (two's-complement wrap)
    logic [RF_DATA_W:0] w_wide;

    always_comb begin
        w_wide = '0;
        case (i_op)
            OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  w_wide = {1'b0, i_a & i_b};
            OP_OR:   w_wide = {1'b0, i_a | i_b};
            OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
            default: w_wide = '0;
        endcase
    end

    assign o_result = w_wide[RF_DATA_W-1:0];
    assign o_carry  = w_wide[RF_DATA_W];
    assign o_zero   = (o_result == '0);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle fetch/decode/read/exec/writeback sequencer.
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 level; leaves IDLE when high
//   o_instr_addr            ROM address (= PC); i_instr_data valid one cycle later
//   o_rf_read_en/_write_en  registered one-cycle strobes to the edge-triggered register file
//   o_rf_read1/2_addr       read addresses, o_rf_write_addr/_data write address/data
//   i_rf_read1/2_data       register-file read data
//   o_busy, o_halted        status; o_zero_flag, o_carry_flag from the last ALU op
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic [PC_WIDTH-1:0]  o_instr_addr,
    input  logic [INSTR_W-1:0]   i_instr_data,
    output logic                 o_rf_read_en,
    output logic                 o_rf_write_en,
    output logic [RF_ADDR_W-1:0] o_rf_read1_addr,
    output logic [RF_ADDR_W-1:0] o_rf_read2_addr,
    output logic [RF_ADDR_W-1:0] o_rf_write_addr,
    output logic [RF_DATA_W-1:0] o_rf_write_data,
    input  logic [RF_DATA_W-1:0] i_rf_read1_data,
    input  logic [RF_DATA_W-1:0] i_rf_read2_data,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_zero_flag,
    output logic                 o_carry_flag
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_e               r_state, w_state_next;
    logic [PC_WIDTH-1:0]  r_pc, w_pc_inc, w_imm_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic [OPC_W-1:0]     w_dec_op, w_ir_op;
    logic [RF_ADDR_W-1:0] w_dec_rd, r_rd1_addr;
    logic [RF_DATA_W-1:0] r_wdata, w_alu_result;
    logic                 r_read_en, r_write_en, r_zero, r_carry;
    logic                 w_alu_carry, w_alu_zero, w_branch;

    assign w_dec_op = i_instr_data[OPC_LSB +: OPC_W];
    assign w_dec_rd = i_instr_data[RD_LSB +: RF_ADDR_W];
    assign w_ir_op  = r_ir[OPC_LSB +: OPC_W];
    assign w_pc_inc = r_pc + PC_ONE;
    assign w_imm_pc = PC_WIDTH'(r_ir[IMM_LSB +: IMM_W]);
    assign w_branch = (w_ir_op == OP_JMP) || ((w_ir_op == OP_BEQZ) && (i_rf_read1_data == '0));

    cpu_alu u_alu (
        .i_op     (w_ir_op),
        .i_a      (i_rf_read1_data),
        .i_b      (i_rf_read2_data),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (i_start) w_state_next = StFetch;
            StFetch:  w_state_next = StDecode;
            StDecode: begin
                if (w_dec_op == OP_HALT)      w_state_next = StHalt;
                else if (op_reads_rf(w_dec_op)) w_state_next = StRead;
                else                            w_state_next = StExec;
            end
            StRead:   w_state_next = StExec;
            StExec:   w_state_next = op_writes_rf(w_ir_op) ? StWb : StFetch;
            StWb:     w_state_next = StFetch;
            StHalt:   w_state_next = StHalt;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_rd1_addr <= '0;
            r_wdata    <= '0;
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            // Strobes follow the state they belong to, straight from a flop
            r_read_en  <= (w_state_next == StRead);
            r_write_en <= (w_state_next == StWb);
            case (r_state)
                StDecode: begin
                    r_ir       <= i_instr_data;
                    // Port-1 address is muxed here so the output comes straight off a flop
                    r_rd1_addr <= (w_dec_op == OP_BEQZ) ? w_dec_rd
                                                        : i_instr_data[RS1_LSB +: RF_ADDR_W];
                end
                StExec: begin
                    if (w_ir_op == OP_LDI) begin
                        r_wdata <= r_ir[IMM_LSB +: IMM_W];
                    end else if (w_ir_op == OP_MOV) begin
                        r_wdata <= i_rf_read1_data;
                    end else if (op_is_alu(w_ir_op)) begin
                        r_wdata <= w_alu_result;
                        r_zero  <= w_alu_zero;
                        if ((w_ir_op == OP_ADD) || (w_ir_op == OP_SUB)) r_carry <= w_alu_carry;
                    end
                    // Writing ops advance PC in WB instead
                    if (w_branch)                    r_pc <= w_imm_pc;
                    else if (!op_writes_rf(w_ir_op)) r_pc <= w_pc_inc;
                end
                StWb:    r_pc <= w_pc_inc;
                default: ;
            endcase
        end
    end

    assign o_instr_addr    = r_pc;
    assign o_rf_read_en    = r_read_en;
    assign o_rf_write_en   = r_write_en;
    assign o_rf_read1_addr = r_rd1_addr;
    assign o_rf_read2_addr = r_ir[RS2_LSB +: RF_ADDR_W];
    assign o_rf_write_addr = r_ir[RD_LSB +: RF_ADDR_W];
    assign o_rf_write_data = r_wdata;
    assign o_busy          = (r_state != StIdle) && (r_state != StHalt);
    assign o_halted        = (r_state == StHalt);
    assign o_zero_flag     = r_zero;
    assign o_carry_flag    = r_carry;

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit microprocessor. It sits directly upstream of the 16x8 register file and drives that file's edge-sensitive read_en/write_en strobes, its addresses and its write data. It also consumes the file's read1/read2 data through an internal ALU. Instructions come from a synchronous instruction ROM with 1-cycle read latency.

Parameters:
PC_WIDTH, 8, width of program counter and instr_addr
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level; leaves IDLE when high
instr_addr  out  PC_WIDTH  ROM address, equals PC
instr_data  in  16  ROM data, valid one cycle after instr_addr changes
rf_read_en  out  1  register-file read strobe, one-cycle pulse
rf_write_en  out  1  register-file write strobe, one-cycle pulse
rf_read1_addr  out  4  rs1 field
rf_read2_addr  out  4  rs2 field
rf_write_addr  out  4  rd field
rf_write_data  out  8  ALU result / immediate
rf_read1_data  in  8  register-file read port 1
rf_read2_data  in  8  register-file read port 2
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
zero_flag  out  1  result==0 of last ALU op
carry_flag  out  1  carry/borrow of last ADD/SUB

Behaviour:
- Reset (async): state=IDLE, PC=RESET_PC, IR=0, all rf_* outputs=0, strobes=0, flags=0, busy=0, halted=0. Reset while a strobe is high drops it immediately; a partial write is not guaranteed.
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2, [7:0] imm8.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= rs1 op rs2.
  - 6 LDI: rd <= imm8.
  - 7 MOV: rd <= rs1.
  - 8 JMP: PC <= imm8.
  - 9 BEQZ: if reg[rd]==0 then PC <= imm8. rd is read through the rs1 port.
  - F HALT.
  - A-E: treated as NOP.
- States: IDLE, FETCH, DECODE, READ, EXEC, WB, HALT.
- Transitions:
  - IDLE -> FETCH when start=1.
  - FETCH -> DECODE. instr_addr=PC is stable during FETCH.
  - DECODE: IR <= instr_data at the edge ending DECODE. Next state: READ for ALU/MOV/BEQZ; EXEC for LDI/JMP/NOP; HALT for HALT.
  - READ: rf_read_en=1 for exactly this cycle. Addresses are driven from IR from DECODE+1 onward, so they are stable before the strobe rises. Next state: EXEC.
  - EXEC:
    - Compute result, register it into rf_write_data, update flags (ALU ops only).
    - ALU/MOV/LDI -> WB.
    - JMP/BEQZ -> FETCH with the new PC.
    - NOP -> FETCH with PC+1.
  - WB: rf_write_en=1 for exactly this cycle. rf_write_addr/rf_write_data are unchanged from EXEC. PC <= PC+1. Next state: FETCH.
  - HALT: stays until rst. start is ignored.
- Latencies (cycles from FETCH entry to next FETCH): ALU/MOV 5; LDI 4; NOP/JMP 3; BEQZ 4.
- rf_read_en and rf_write_en are never high in the same cycle. Both are registered (glitch-free), because the register file is edge-triggered on them.
- Arithmetic:
  - ADD: 9-bit sum; carry = bit 8; result = low 8 bits.
  - SUB: result = rs1-rs2 mod 256; carry = 1 when rs1<rs2 (borrow).
  - Logic ops/MOV: carry unchanged. MOV also leaves zero unchanged.
- PC is modulo 2^PC_WIDTH: 0xFF+1 wraps to 0x00. A BEQZ not taken also increments PC.
- start pulsing while busy has no effect.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_NOP..OP_HALT);
  - state encoding constants;
  - instruction field bit positions;
  - the register-file address width (4) and data width (8).
- One sub-module, cpu_alu: combinational, taking opcode, a, b and producing result[7:0], carry, zero. cpu_ctrl_seq registers its outputs.

Test Plan:
1. Reset and start: assert rst mid-run -> all outputs 0 and busy=0 immediately. Release rst, pulse start -> instr_addr=0x00, first rf_read_en pulse never appears for an LDI.
2. ROM LDI R1,0x05; LDI R2,0x03; ADD R3,R1,R2 (a stub models the register file) -> write pulses (1,0x05), (2,0x03), (3,0x08). ADD has exactly 5 cycles FETCH-to-FETCH. carry=0, zero=0.
3. SUB R4,R2,R1 with R2=0x03, R1=0x05 -> write (4,0xFE), carry=1. ADD 0xFF+0x01 -> write 0x00, carry=1, zero=1.
4. BEQZ R0,0x10 with R0=0 -> next instr_addr=0x10. With R0=0x01 -> next instr_addr = PC+1. JMP 0x00 at address 0xFF and NOP at 0xFF -> both give instr_addr 0x00 (wrap).
5. HALT -> halted=1, busy=0, no further strobes for 50 cycles despite start=1. Only rst exits.
6. Assert rst during the WB cycle -> rf_write_en falls asynchronously, state=IDLE. Checker confirms rf_read_en & rf_write_en were never simultaneously 1 across all tests.
